// File: rtl/pll_drp_sequencer.sv
// PLL dynamic reconfiguration sequencer.
// Holds the PLL in reset and read-modify-writes NUM_REGS DRP registers. It
// then releases reset, waits for a synchronized LOCKED and reports SRDY or ERR.
// DRP handshake: DEN is a one-cycle strobe (DWE qualifies it as a write) and
// DRDY is accepted only while waiting on that access. No new DEN is issued
// until DRDY arrives or the wait times out.
module pll_drp_sequencer #(
    parameter int NUM_REGS     = 8,
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                     DCLK,
    input  logic                     RST,
    input  logic                     SEN,
    input  logic [7*NUM_REGS-1:0]    CFG_ADDR,
    input  logic [16*NUM_REGS-1:0]   CFG_MASK,
    input  logic [16*NUM_REGS-1:0]   CFG_DATA,
    output logic                     SRDY,
    output logic                     BUSY,
    output logic                     ERR,
    output logic                     RST_PLL,
    output logic [6:0]               DADDR,
    output logic                     DEN,
    output logic                     DWE,
    output logic [15:0]              DI,
    input  logic [15:0]              DO,
    input  logic                     DRDY,
    input  logic                     LOCKED,
    output logic [3:0]               dbg_state
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_HOLD      = 4'd1;
    localparam logic [3:0] S_READ      = 4'd2;
    localparam logic [3:0] S_WAIT_R    = 4'd3;
    localparam logic [3:0] S_MODIFY    = 4'd4;
    localparam logic [3:0] S_WRITE     = 4'd5;
    localparam logic [3:0] S_WAIT_W    = 4'd6;
    localparam logic [3:0] S_RELEASE   = 4'd7;
    localparam logic [3:0] S_WAIT_LOCK = 4'd8;
    localparam logic [3:0] S_DONE      = 4'd9;
    localparam logic [3:0] S_ABORT     = 4'd10;

    logic [3:0]    state;
    logic [IW-1:0] idx;
    logic [31:0]   cnt;
    logic [15:0]   do_q;
    logic          lock_meta;
    logic          lock_s;

    logic [6:0]    addr_m [NUM_REGS];
    logic [15:0]   mask_m [NUM_REGS];
    logic [15:0]   data_m [NUM_REGS];

    assign dbg_state = state;

    // Two-flop synchronizer for the asynchronous LOCKED input.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= LOCKED;
            lock_s    <= lock_meta;
        end
    end

    // Snapshot of the configuration table taken when a sequence is accepted.
    always_ff @(posedge DCLK) begin
        if (state == S_IDLE && SEN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                addr_m[i] <= CFG_ADDR[7*i +: 7];
                mask_m[i] <= CFG_MASK[16*i +: 16];
                data_m[i] <= CFG_DATA[16*i +: 16];
            end
        end
    end

    // Sequencer FSM; every output is set on the transition into the state that owns it.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            idx     <= '0;
            cnt     <= '0;
            do_q    <= '0;
            SRDY    <= 1'b0;
            BUSY    <= 1'b0;
            ERR     <= 1'b0;
            RST_PLL <= 1'b0;
            DADDR   <= '0;
            DEN     <= 1'b0;
            DWE     <= 1'b0;
            DI      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (SEN) begin
                        ERR     <= 1'b0;
                        BUSY    <= 1'b1;
                        RST_PLL <= 1'b1;
                        idx     <= '0;
                        cnt     <= '0;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt == 32'(RST_HOLD - 1)) begin
                        DADDR <= addr_m[idx];
                        DEN   <= 1'b1;
                        DWE   <= 1'b0;
                        state <= S_READ;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_READ: begin
                    DEN   <= 1'b0;
                    cnt   <= '0;
                    state <= S_WAIT_R;
                end
                S_WAIT_R: begin
                    // DRDY wins over an expiring timeout in the same cycle.
                    if (DRDY) begin
                        do_q  <= DO;
                        state <= S_MODIFY;
                    end else if (cnt == 32'(DRDY_TIMEOUT - 1)) begin
                        ERR     <= 1'b1;
                        RST_PLL <= 1'b0;
                        state   <= S_ABORT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_MODIFY: begin
                    DI    <= (do_q & mask_m[idx]) | (data_m[idx] & ~mask_m[idx]);
                    DEN   <= 1'b1;
                    DWE   <= 1'b1;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    DEN   <= 1'b0;
                    DWE   <= 1'b0;
                    cnt   <= '0;
                    state <= S_WAIT_W;
                end
                S_WAIT_W: begin
                    if (DRDY) begin
                        if (idx == IW'(NUM_REGS - 1)) begin
                            RST_PLL <= 1'b0;
                            state   <= S_RELEASE;
                        end else begin
                            idx   <= idx + 1'b1;
                            DADDR <= addr_m[idx + 1'b1];
                            DEN   <= 1'b1;
                            DWE   <= 1'b0;
                            state <= S_READ;
                        end
                    end else if (cnt == 32'(DRDY_TIMEOUT - 1)) begin
                        ERR     <= 1'b1;
                        RST_PLL <= 1'b0;
                        state   <= S_ABORT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_RELEASE: begin
                    cnt   <= '0;
                    state <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        SRDY  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_DONE;
                    end else if (cnt == 32'(LOCK_TIMEOUT - 1)) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    SRDY  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ABORT: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Bench for pll_drp_sequencer: DRP register model, PLL lock model, access
// scoreboard and protocol monitor, directed vectors plus random sequences.
module tb_pll_drp_sequencer;

    localparam int NR = 2;
    localparam int RH = 4;
    localparam int DT = 64;
    localparam int LT = 4096;

    logic              DCLK;
    logic              RST;
    logic              SEN;
    logic [7*NR-1:0]   CFG_ADDR;
    logic [16*NR-1:0]  CFG_MASK;
    logic [16*NR-1:0]  CFG_DATA;
    logic              SRDY;
    logic              BUSY;
    logic              ERR;
    logic              RST_PLL;
    logic [6:0]        DADDR;
    logic              DEN;
    logic              DWE;
    logic [15:0]       DI;
    logic [15:0]       DO;
    logic              DRDY;
    logic              LOCKED;
    logic [3:0]        dbg_state;

    pll_drp_sequencer #(
        .NUM_REGS(NR), .RST_HOLD(RH), .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)
    ) dut (
        .DCLK(DCLK), .RST(RST), .SEN(SEN),
        .CFG_ADDR(CFG_ADDR), .CFG_MASK(CFG_MASK), .CFG_DATA(CFG_DATA),
        .SRDY(SRDY), .BUSY(BUSY), .ERR(ERR), .RST_PLL(RST_PLL),
        .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI),
        .DO(DO), .DRDY(DRDY), .LOCKED(LOCKED), .dbg_state(dbg_state)
    );

    // clock
    initial DCLK = 1'b0;
    always #5 DCLK = ~DCLK;

    typedef struct {
        logic [6:0]  a0, a1;
        logic [15:0] m0, m1, d0, d1;
        logic [15:0] i0, i1;
        logic [15:0] x0, x1;
    } vec_t;

    vec_t        vecs [3];
    logic [6:0]  cfg_a [NR];
    logic [15:0] cfg_m [NR];
    logic [15:0] cfg_d [NR];
    logic [15:0] dev_mem [128];
    logic [15:0] ref_mem [128];
    logic [23:0] exp_q [$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   drp_delay = 3;
    bit   drdy_en = 1'b1;
    int   drp_cnt = 0;
    logic [6:0] drp_addr = '0;
    logic drp_we = 1'b0;
    bit   lock_en = 1'b1;
    int   lock_cnt = 0;
    int   den_cnt = 0;
    int   srdy_cnt = 0;
    bit   prev_den = 1'b0;
    bit   outstanding = 1'b0;
    logic prev_err = 1'b0;
    logic prev_rst_pll = 1'b0;
    int   last_den_cyc = 0;
    int   lock_rise_cyc = 0;
    int   srdy_cyc = 0;
    int   err_rise_cyc = 0;
    int   rst_fall_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One DCLK cycle: advance to the falling edge, monitor, then drive the DRP and lock models.
    task automatic step();
        logic [23:0] e;
        @(negedge DCLK);
        cyc++;
        check("dwe_without_den", {31'd0, DWE & ~DEN}, 32'd0);
        if (DEN) begin
            den_cnt++;
            check("den_back_to_back", {31'd0, prev_den}, 32'd0);
            check("den_while_outstanding", {31'd0, outstanding}, 32'd0);
            check("rst_pll_during_den", {31'd0, RST_PLL}, 32'd1);
            outstanding = 1'b1;
            last_den_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access actual=we%0b addr %0h required=none", DWE, DADDR);
            end else begin
                e = exp_q.pop_front();
                check("access_we", {31'd0, DWE}, {31'd0, e[23]});
                check("access_addr", {25'd0, DADDR}, {25'd0, e[22:16]});
                if (e[23]) check("write_data", {16'd0, DI}, {16'd0, e[15:0]});
            end
        end
        if (SRDY) begin
            srdy_cnt++;
            srdy_cyc = cyc;
        end
        if (ERR && !prev_err) err_rise_cyc = cyc;
        if (!RST_PLL && prev_rst_pll) rst_fall_cyc = cyc;
        prev_den = DEN;
        prev_err = ERR;
        prev_rst_pll = RST_PLL;
        if (!BUSY) outstanding = 1'b0;
        // DRP register model
        DRDY = 1'b0;
        if (drp_cnt > 0) begin
            drp_cnt--;
            if (drp_cnt == 0) begin
                DRDY = 1'b1;
                outstanding = 1'b0;
                if (!drp_we) DO = dev_mem[drp_addr];
            end
        end
        if (DEN && drdy_en) begin
            drp_cnt = drp_delay;
            drp_addr = DADDR;
            drp_we = DWE;
            if (DWE) dev_mem[DADDR] = DI;
        end
        // PLL lock model: locks a few cycles after its reset is released
        if (RST_PLL || !lock_en) begin
            LOCKED = 1'b0;
            lock_cnt = 0;
        end else if (!LOCKED) begin
            lock_cnt++;
            if (lock_cnt >= 5) begin
                LOCKED = 1'b1;
                lock_rise_cyc = cyc;
            end
        end
    endtask

    task automatic start_seq();
        den_cnt = 0;
        srdy_cnt = 0;
        for (int i = 0; i < NR; i++) begin
            CFG_ADDR[7*i +: 7]   = cfg_a[i];
            CFG_MASK[16*i +: 16] = cfg_m[i];
            CFG_DATA[16*i +: 16] = cfg_d[i];
        end
        SEN = 1'b1;
        step();
        SEN = 1'b0;
        // the running sequence must ignore these
        CFG_ADDR = 14'($urandom);
        CFG_MASK = $urandom;
        CFG_DATA = $urandom;
        check("busy_on_start", {31'd0, BUSY}, 32'd1);
        check("rst_pll_on_start", {31'd0, RST_PLL}, 32'd1);
        check("err_cleared_on_start", {31'd0, ERR}, 32'd0);
    endtask

    task automatic wait_idle(input int max_cyc, input bit noise);
        int n;
        n = 0;
        do begin
            if (noise) SEN = (cyc % 3 == 0);
            step();
            n++;
        end while (BUSY && n < max_cyc);
        SEN = 1'b0;
        check("busy_drops", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic expect_ok();
        check("srdy_count", srdy_cnt, 1);
        check("err_clear", {31'd0, ERR}, 32'd0);
        check("all_accesses_done", exp_q.size(), 0);
        check("den_count", den_cnt, 2 * NR);
        check("srdy_after_lock_s", srdy_cyc - lock_rise_cyc, 3);
        check("daddr_held", {25'd0, DADDR}, {25'd0, cfg_a[NR-1]});
        check("rst_pll_released", {31'd0, RST_PLL}, 32'd0);
        step();
        check("srdy_one_cycle", {31'd0, SRDY}, 32'd0);
    endtask

    task automatic load_vec(input vec_t v);
        cfg_a[0] = v.a0; cfg_m[0] = v.m0; cfg_d[0] = v.d0;
        cfg_a[1] = v.a1; cfg_m[1] = v.m1; cfg_d[1] = v.d1;
        dev_mem[v.a1] = v.i1;
        dev_mem[v.a0] = v.i0;
        exp_q.delete();
        exp_q.push_back({1'b0, v.a0, 16'h0});
        exp_q.push_back({1'b1, v.a0, v.x0});
        exp_q.push_back({1'b0, v.a1, 16'h0});
        exp_q.push_back({1'b1, v.a1, v.x1});
    endtask

    // Reference: each entry keeps read-back bits where the mask is 1, takes new bits elsewhere.
    task automatic model_expect();
        logic [15:0] old_v, new_v;
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            old_v = ref_mem[cfg_a[i]];
            for (int b = 0; b < 16; b++)
                new_v[b] = cfg_m[i][b] ? old_v[b] : cfg_d[i][b];
            ref_mem[cfg_a[i]] = new_v;
            exp_q.push_back({1'b0, cfg_a[i], 16'h0});
            exp_q.push_back({1'b1, cfg_a[i], new_v});
        end
    endtask

    initial begin
        vecs[0] = '{a0: 7'h08, a1: 7'h09, m0: 16'h1000, m1: 16'hFC00, d0: 16'h00C3, d1: 16'h0080,
                    i0: 16'hFFFF, i1: 16'hFFFF, x0: 16'h10C3, x1: 16'hFC80};
        vecs[1] = '{a0: 7'h10, a1: 7'h11, m0: 16'h00FF, m1: 16'h0000, d0: 16'hAB00, d1: 16'h5A5A,
                    i0: 16'h1234, i1: 16'hFFFF, x0: 16'hAB34, x1: 16'h5A5A};
        vecs[2] = '{a0: 7'h20, a1: 7'h20, m0: 16'hFF00, m1: 16'h00FF, d0: 16'h0011, d1: 16'h2200,
                    i0: 16'hA5A5, i1: 16'hA5A5, x0: 16'hA511, x1: 16'h2211};
        for (int i = 0; i < 128; i++) dev_mem[i] = 16'h0;

        // reset
        RST = 1'b1; SEN = 1'b0; DO = '0; DRDY = 1'b0; LOCKED = 1'b0;
        CFG_ADDR = '0; CFG_MASK = '0; CFG_DATA = '0;
        repeat (3) @(negedge DCLK);
        check("rst_srdy", {31'd0, SRDY}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_err", {31'd0, ERR}, 32'd0);
        check("rst_rst_pll", {31'd0, RST_PLL}, 32'd0);
        check("rst_den_dwe", {30'd0, DEN, DWE}, 32'd0);
        check("rst_daddr_di", {9'd0, DADDR, DI}, 32'd0);
        check("rst_state", {28'd0, dbg_state}, 32'd0);
        RST = 1'b0;
        repeat (2) step();

        // directed vectors
        for (int v = 0; v < 3; v++) begin
            load_vec(vecs[v]);
            start_seq();
            wait_idle(400, 1'b0);
            expect_ok();
            check("dev_mem_final", {16'd0, dev_mem[vecs[v].a1]}, {16'd0, vecs[v].x1});
        end

        // DRDY exactly at timeout expiry counts as success
        drp_delay = DT;
        load_vec(vecs[1]);
        start_seq();
        wait_idle(2000, 1'b0);
        expect_ok();

        // DRDY one cycle late aborts the first read
        drp_delay = DT + 1;
        load_vec(vecs[0]);
        start_seq();
        wait_idle(400, 1'b0);
        check("late_drdy_den_count", den_cnt, 1);
        check("late_drdy_err", {31'd0, ERR}, 32'd1);
        check("late_drdy_no_srdy", srdy_cnt, 0);
        repeat (3) step();
        drp_delay = 3;

        // DRP never answers the first read
        drdy_en = 1'b0;
        load_vec(vecs[0]);
        start_seq();
        wait_idle(400, 1'b0);
        check("abort_den_count", den_cnt, 1);
        check("abort_latency", err_rise_cyc - last_den_cyc, DT + 1);
        check("abort_err", {31'd0, ERR}, 32'd1);
        check("abort_rst_pll", {31'd0, RST_PLL}, 32'd0);
        check("abort_den", {30'd0, DEN, DWE}, 32'd0);
        check("abort_no_srdy", srdy_cnt, 0);
        drdy_en = 1'b1;
        step();

        // lock never arrives, then a retry with a working PLL clears ERR
        lock_en = 1'b0;
        load_vec(vecs[0]);
        start_seq();
        wait_idle(LT + 400, 1'b0);
        check("lock_to_err", {31'd0, ERR}, 32'd1);
        check("lock_to_latency", err_rise_cyc - rst_fall_cyc, LT + 1);
        check("lock_to_no_srdy", srdy_cnt, 0);
        check("lock_to_accesses", exp_q.size(), 0);
        lock_en = 1'b1;
        repeat (8) step();
        load_vec(vecs[0]);
        start_seq();
        wait_idle(400, 1'b0);
        expect_ok();

        // SEN pulses while busy are ignored
        load_vec(vecs[1]);
        start_seq();
        wait_idle(400, 1'b1);
        expect_ok();
        repeat (3) step();
        check("no_restart_after_noise", {31'd0, BUSY}, 32'd0);

        // randomized sequences against the reference model
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NR; i++) begin
                cfg_a[i] = 7'($urandom);
                cfg_m[i] = 16'($urandom);
                cfg_d[i] = 16'($urandom);
                dev_mem[cfg_a[i]] = 16'($urandom);
            end
            for (int k = 0; k < 128; k++) ref_mem[k] = dev_mem[k];
            model_expect();
            drp_delay = $urandom_range(1, 10);
            start_seq();
            wait_idle(600, 1'b0);
            expect_ok();
        end
        drp_delay = 3;

        // asynchronous reset during WAIT_W, then a clean restart from entry 0
        load_vec(vecs[0]);
        start_seq();
        begin
            int n;
            n = 0;
            while (!(DEN && DWE) && n < 100) begin
                step();
                n++;
            end
            check("reached_write", {31'd0, DEN & DWE}, 32'd1);
        end
        step();
        #2 RST = 1'b1;
        #1;
        check("arst_busy", {31'd0, BUSY}, 32'd0);
        check("arst_rst_pll", {31'd0, RST_PLL}, 32'd0);
        check("arst_den_dwe", {30'd0, DEN, DWE}, 32'd0);
        check("arst_daddr_di", {9'd0, DADDR, DI}, 32'd0);
        check("arst_state", {28'd0, dbg_state}, 32'd0);
        drp_cnt = 0;
        DRDY = 1'b0;
        outstanding = 1'b0;
        prev_den = 1'b0;
        step();
        RST = 1'b0;
        repeat (8) step();
        load_vec(vecs[0]);
        start_seq();
        wait_idle(400, 1'b0);
        expect_ok();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
